// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks a masked set of the 16 registers and streams
// each one as a 5-byte frame. Define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module reg_dump_reader #(
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] mask,
  output logic [3:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SEND,
`ifdef REG_DUMP_CHECKSUM_EN
    TRAIL,
`endif
    DONE
  } state_t;

  state_t      state;
  logic [15:0] mask_q;
  logic [3:0]  idx;
  logic [2:0]  cnt;
  // out_data is the top byte of the frame; sh holds the remaining 32 bits
  logic [31:0] sh;
  logic        acc;

  assign acc     = out_valid && out_ready;
  assign rd_addr = idx;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_nx;
  assign csum_nx = acc ? (csum ^ out_data) : csum;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mask_q    <= '0;
      idx       <= '0;
      cnt       <= '0;
      sh        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask_q <= mask;
            idx    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SCAN;
`ifdef REG_DUMP_CHECKSUM_EN
            csum   <= '0;
`endif
          end
        end
        SCAN: begin
          if (mask_q[idx]) begin
            // snapshot taken here; later register writes cannot reach the frame
            out_data  <= {HDR_TAG, idx};
            sh        <= rd_data;
            out_valid <= 1'b1;
            state     <= SEND;
          end else if (idx == 4'd15) begin
`ifdef REG_DUMP_CHECKSUM_EN
            out_data  <= csum;
            out_valid <= 1'b1;
            state     <= TRAIL;
`else
            done      <= 1'b1;
            state     <= DONE;
`endif
          end else begin
            idx <= idx + 4'd1;
          end
        end
        SEND: begin
          if (acc) begin
`ifdef REG_DUMP_CHECKSUM_EN
            csum <= csum_nx;
`endif
            if (cnt == 3'd4) begin
              cnt <= '0;
              if (idx == 4'd15) begin
`ifdef REG_DUMP_CHECKSUM_EN
                out_data  <= csum_nx;
                state     <= TRAIL;
`else
                out_data  <= '0;
                out_valid <= 1'b0;
                done      <= 1'b1;
                state     <= DONE;
`endif
              end else begin
                out_data  <= '0;
                out_valid <= 1'b0;
                idx       <= idx + 4'd1;
                state     <= SCAN;
              end
            end else begin
              cnt      <= cnt + 3'd1;
              out_data <= sh[31:24];
              sh       <= {sh[23:0], 8'h00};
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        TRAIL: begin
          if (acc) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader: expected byte streams and completion times
// are derived from the mask, register contents and a free-running r15 (PC).
module tb_reg_dump_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mask = '0;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [31:0] regs [16];
  logic [31:0] pc = 32'h1000;
  logic [7:0]  got_q [$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_byte = '0;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  always #5 clock = ~clock;
  always @(posedge clock) pc <= pc + 32'd1;
  assign rd_data = (rd_addr == 4'd15) ? pc : regs[rd_addr];

  reg_dump_reader #(.HDR_TAG(4'hA)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mask(mask),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // capture accepted bytes and verify a stalled byte stays put
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) chk("hold", 32'({out_valid, out_data}), 32'({1'b1, hold_byte}));
      if (out_valid && out_ready) got_q.push_back(out_data);
      hold_pend <= out_valid && !out_ready;
      hold_byte <= out_data;
    end
  end

  // mode 0: ready always 1; mode 2: 3 stall cycles per byte; mode 3: random ready
  task automatic run_dump(input logic [15:0] m_in, input int mode, input int snap_k,
                          input int restart_k, input string nm);
    logic [15:0] m;
    logic [7:0]  exp_q [$];
    logic [7:0]  cs;
    logic [31:0] v, pc_s;
    int pre, bcyc, exp_done, done_k, dn, stall, nb;
    m = m_in;
    if (mode != 0) m[15] = 1'b0;
    got_q.delete();
    @(posedge clock); #1 start = 1'b1; mask = m;
    @(posedge clock); #1 start = 1'b0; mask = 16'($urandom);
    pc_s = pc;
    pre = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        v = (i == 15) ? pc_s + 32'(pre) : regs[i];
        exp_q.push_back({4'hA, 4'(i)});
        exp_q.push_back(v[31:24]);
        exp_q.push_back(v[23:16]);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
        pre += 6;
      end else begin
        pre += 1;
      end
    end
    cs = '0;
    foreach (exp_q[i]) cs ^= exp_q[i];
    if (CSUM) exp_q.push_back(cs);
    bcyc = (mode == 2) ? 4 : 1;
    exp_done = 1 + (CSUM ? bcyc : 0);
    for (int i = 0; i < 16; i++) exp_done += m[i] ? 1 + 5 * bcyc : 1;
    done_k = 0; dn = 0; stall = 0;
    for (int k = 1; k <= 3000; k++) begin
      if (k > 1) begin @(posedge clock); #1; end
      if (k == snap_k) regs[0] = 32'hFFFFFFFF;
      start = (k == restart_k);
      if (k == restart_k) mask = 16'hFFFF;
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 3) out_ready = 1'($urandom_range(0, 1));
      else if (!out_valid) begin out_ready = 1'b0; stall = 0; end
      else if (stall < 3) begin out_ready = 1'b0; stall++; end
      else begin out_ready = 1'b1; stall = 0; end
      @(negedge clock);
      if (k == 1) chk({nm, "_busy_run"}, 32'(busy), 32'd1);
      if (done) begin
        dn++;
        if (done_k == 0) done_k = k;
      end
      if (done_k != 0 && k >= done_k + 2) break;
    end
    start = 1'b0;
    if (mode != 3) chk({nm, "_done_cycle"}, 32'(done_k), 32'(exp_done));
    else chk({nm, "_done_seen"}, 32'(done_k != 0), 32'd1);
    chk({nm, "_done_cnt"}, 32'(dn), 32'd1);
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    chk({nm, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++)
      chk($sformatf("%s_byte%0d", nm, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    #2;
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #10 reset_n = 1'b1;

    regs[0] = 32'h12345678;
    run_dump(16'h0001, 0, 0, 0, "single");
    regs[1] = 32'hDEADBEEF;
    run_dump(16'h8002, 0, 0, 0, "r1_r15");
    run_dump(16'h0001, 2, 0, 0, "bp");
    run_dump(16'h0000, 0, 0, 5, "empty");
    run_dump(16'h0001, 0, 3, 0, "snap");

    // reset while the second byte of a frame is on the bus
    regs[0] = 32'h12345678;
    got_q.delete();
    @(posedge clock); #1 start = 1'b1; mask = 16'h0001;
    @(posedge clock); #1 start = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1 out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    chk("mid_vld", 32'(out_valid), 32'd1);
    chk("mid_byte2", 32'(out_data), 32'h12);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_addr", 32'(rd_addr), 32'd0);
    @(negedge clock);
    @(posedge clock); #3 reset_n = 1'b1;
    run_dump(16'h0001, 0, 0, 0, "post_rst");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 15; i++) regs[i] = $urandom;
      run_dump(16'($urandom), (t % 2 == 0) ? 3 : 0, 0, 0, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine for the single-cycle CPU's 16 x 32-bit register file. On a start pulse it walks a masked subset of registers through a spare asynchronous read port, snapshots each selected register, and streams it out as framed bytes over a valid/ready interface. The stream normally feeds the board UART transmitter. It is the observing end of the register file: the core writes registers, and this block reads them out without stalling the core.

## Interface
Parameters:
- `HDR_TAG`, default `4'hA`: upper nibble of every per-register header byte.

Ports:
- `clock` — input, 1 bit. Single clock shared with the core; all state updates on the rising edge.
- `reset_n` — input, 1 bit. Reset is asynchronous and active-low.
- `start` — input, 1 bit. Single-cycle request to begin a dump. Sampled only in IDLE.
- `mask` — input, 16 bits. Bit i selects register i. Latched on an accepted `start`.
- `rd_addr` — output, 4 bits. Drives the register file's spare read address.
- `rd_data` — input, 32 bits. Combinational read data for `rd_addr`.
- `out_data` — output, 8 bits. Stream byte.
- `out_valid` — output, 1 bit. `out_data` holds a valid byte.
- `out_ready` — input, 1 bit. Sink accepts a byte when `out_valid && out_ready` at a rising edge.
- `busy` — output, 1 bit. High whenever the state is not IDLE.
- `done` — output, 1 bit. One-cycle pulse when a dump completes.

## Operation
- States: IDLE, SCAN, SEND, TRAIL, DONE. TRAIL exists only with the macro defined.
- **IDLE**
  - `start=1` latches `mask` into `mask_q`, sets `idx=0` and `cnt=0`, and moves to SCAN.
  - `start` in any other state is ignored. It is neither queued nor re-latched.
- **SCAN** (one index examined per cycle; `rd_addr = idx`)
  - If `mask_q[idx]=1`: load a 40-bit shift register with `{HDR_TAG, idx, rd_data}` and move to SEND.
  - Else if `idx==15`: move to TRAIL (macro defined) or DONE (macro undefined).
  - Else: `idx` increments.
- **SEND** (five bytes, MSB first)
  - Byte order: header, then `rd_data[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - `out_valid=1`. `out_data` is the top byte of the shift register.
  - On each accepted byte, the shift register shifts left by 8 and `cnt` increments.
  - After the fifth accepted byte, `cnt` returns to 0. Then:
    - If `idx==15`: move to TRAIL or DONE.
    - Else: `idx` increments and the block returns to SCAN.
- **Snapshot rule**
  - The value is captured in the SCAN cycle. Later register-file writes do not alter bytes already framed.
  - r15 changes every cycle, so its dumped value is the PC at capture time.
- **DONE**
  - `done=1` for exactly one cycle, then IDLE.
- **Empty mask**
  - The block scans all 16 indices, sends no data bytes, then completes.
- **Reset**
  - Asserting `reset_n` low at any time, including mid-byte, forces IDLE asynchronously.
  - All outputs go to their reset values immediately. The partial frame is abandoned.
- **Reset values**
  - `rd_addr=0`, `out_data=8'h00`, `out_valid=0`, `busy=0`, `done=0`.
  - Internal state: `mask_q=0`, `idx=0`, `cnt=0`.

## Timing
- Edge 0 samples `start`. SCAN begins in the following cycle with `rd_addr=0`.
- Each unselected index costs exactly 1 cycle. Each selected index costs 1 SCAN cycle plus at least 5 SEND cycles; backpressure extends this.
- `out_valid` rises in the cycle after the SCAN cycle that selected the register.
- Handshake rules:
  - `out_valid` stays high and `out_data` stays stable until accepted.
  - `out_valid` never drops without a transfer, except on reset.
  - `out_ready` may toggle freely and has no combinational path to outputs.
- With the macro undefined, DONE follows the final accepted byte, or the idx=15 SCAN cycle, by one cycle.
- Full dump with all 16 registers selected and no backpressure: 16 x 6 = 96 cycles, then 1 DONE cycle.

## Configuration
- Macro: `REG_DUMP_CHECKSUM_EN`.
- **Defined:**
  - An 8-bit `csum` clears on start and XORs in every accepted byte.
  - TRAIL presents `out_data=csum` with `out_valid=1`. DONE follows the cycle after it is accepted.
  - An empty mask still produces one trailer byte, `8'h00`.
- **Undefined:**
  - No TRAIL state and no `csum` register.
  - The stream ends after the last data byte.

## Test plan
- **Single register.** r0=`32'h12345678`, mask=`16'h0001`, `out_ready` held 1 → bytes A0,12,34,56,78. `done` pulses once. With the macro, a trailer byte `8'hA8` precedes `done`.
- **Two registers including r15.** r1=`32'hDEADBEEF`, mask=`16'h8002` → A1,DE,AD,BE,EF, then AF followed by four bytes equal to the r15 value in the capture cycle. SEND for r15 starts 14 cycles after the r1 frame completes.
- **Backpressure.** Same as the single-register case, with `out_ready` low for 3 cycles on every byte → each byte is held stable while `out_valid=1`. There are no duplicates or drops, and total SEND time is 20 cycles.
- **Empty mask, busy, and restart.** mask=0 → `busy` for 16 SCAN cycles, then `done`, with no data bytes (one `8'h00` trailer with the macro). A `start` pulse during busy is ignored. A new `start` after `done` is accepted.
- **Snapshot.** r0 is overwritten with `32'hFFFFFFFF` two cycles after r0 is captured → the remaining bytes still read 34,56,78.
- **Reset mid-frame.** `reset_n` goes low while byte 2 is presented → `out_valid` and `busy` drop immediately. After release, a new `start` produces a complete, correct frame.
